// File: rtl/gpio_config_loader_if.sv
// Pad configuration bus: serial shift path, strobes, and decoded pad-control fields.
// The loader sits on the slave side; housekeeping/testbench drives the master side.
interface gpio_config_loader_if #(
    parameter int CFG_WIDTH = 13
);
    // Inputs to the loader
    logic [CFG_WIDTH-1:0] gpio_defaults;
    logic                 serial_data_in;
    logic                 serial_shift;
    logic                 serial_load;
    logic                 defaults_reload;

    // Outputs from the loader
    logic                 serial_data_out;
    logic [CFG_WIDTH-1:0] config_word;
    logic                 mgmt_ena;
    logic                 gpio_outenb;
    logic                 gpio_holdover;
    logic                 gpio_inenb;
    logic                 gpio_ib_mode_sel;
    logic                 gpio_ana_en;
    logic                 gpio_ana_sel;
    logic                 gpio_ana_pol;
    logic                 gpio_slow_sel;
    logic                 gpio_vtrip_sel;
    logic [2:0]           gpio_dm;
    logic                 config_updated;
    logic                 load_err;

    modport master (
        output gpio_defaults,
        output serial_data_in,
        output serial_shift,
        output serial_load,
        output defaults_reload,
        input  serial_data_out,
        input  config_word,
        input  mgmt_ena,
        input  gpio_outenb,
        input  gpio_holdover,
        input  gpio_inenb,
        input  gpio_ib_mode_sel,
        input  gpio_ana_en,
        input  gpio_ana_sel,
        input  gpio_ana_pol,
        input  gpio_slow_sel,
        input  gpio_vtrip_sel,
        input  gpio_dm,
        input  config_updated,
        input  load_err
    );

    modport slave (
        input  gpio_defaults,
        input  serial_data_in,
        input  serial_shift,
        input  serial_load,
        input  defaults_reload,
        output serial_data_out,
        output config_word,
        output mgmt_ena,
        output gpio_outenb,
        output gpio_holdover,
        output gpio_inenb,
        output gpio_ib_mode_sel,
        output gpio_ana_en,
        output gpio_ana_sel,
        output gpio_ana_pol,
        output gpio_slow_sel,
        output gpio_vtrip_sel,
        output gpio_dm,
        output config_updated,
        output load_err
    );
endinterface

// File: rtl/gpio_config_loader.sv
// Per-pad config register: daisy-chained serial shift path loaded into a 13-bit active word.
// All outputs come straight from flops, one cycle after the strobe; strobes are never stalled.
module gpio_config_loader #(
    parameter int CFG_WIDTH   = 13,
    parameter bit CHECK_COUNT = 1'b1
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    gpio_config_loader_if.slave pad
);
    if (CFG_WIDTH != 13) begin : g_bad_width
        $error("gpio_config_loader: CFG_WIDTH must be 13");
    end

    localparam logic [3:0] FULL_CNT = 4'(CFG_WIDTH);

    logic [CFG_WIDTH-1:0] shreg_q,  shreg_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic [CFG_WIDTH-1:0] config_q, config_d;
    logic                 updated_q, updated_d;
    logic                 load_err_q, load_err_d;
    logic                 load_ok;

    // The count gate only matters when CHECK_COUNT is set; otherwise any load is taken.
    assign load_ok = !CHECK_COUNT || (bit_cnt_q == FULL_CNT);

    always_comb begin
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        config_d   = config_q;
        updated_d  = 1'b0;
        load_err_d = load_err_q;

        if (pad.serial_shift) begin
            shreg_d = {shreg_q[CFG_WIDTH-2:0], pad.serial_data_in};
            if (bit_cnt_q != FULL_CNT) begin
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
        end

        // Reload outranks load; both restart the bit count after any same-cycle shift.
        if (pad.defaults_reload) begin
            config_d   = pad.gpio_defaults;
            bit_cnt_d  = 4'd0;
            load_err_d = 1'b0;
            updated_d  = 1'b1;
        end else if (pad.serial_load) begin
            bit_cnt_d = 4'd0;
            if (load_ok) begin
                config_d  = shreg_q;
                updated_d = 1'b1;
            end else begin
                load_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            shreg_q    <= '0;
            bit_cnt_q  <= 4'd0;
            config_q   <= pad.gpio_defaults;
            updated_q  <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            config_q   <= config_d;
            updated_q  <= updated_d;
            load_err_q <= load_err_d;
        end
    end

    assign pad.serial_data_out  = shreg_q[CFG_WIDTH-1];
    assign pad.config_word      = config_q;
    assign pad.mgmt_ena         = config_q[0];
    assign pad.gpio_outenb      = config_q[1];
    assign pad.gpio_holdover    = config_q[2];
    assign pad.gpio_inenb       = config_q[3];
    assign pad.gpio_ib_mode_sel = config_q[4];
    assign pad.gpio_ana_en      = config_q[5];
    assign pad.gpio_ana_sel     = config_q[6];
    assign pad.gpio_ana_pol     = config_q[7];
    assign pad.gpio_slow_sel    = config_q[8];
    assign pad.gpio_vtrip_sel   = config_q[9];
    assign pad.gpio_dm          = config_q[12:10];
    assign pad.config_updated   = updated_q;
    assign pad.load_err         = load_err_q;
endmodule

// File: tb/tb_gpio_config_loader.sv
// Directed bench: two chained pads (near fed by the bench, far fed by near's serial_data_out).
module tb_gpio_config_loader;
    logic        clk = 1'b0;
    logic        rst;
    logic [12:0] dflt;
    logic        sdi, shift, load, reload;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    gpio_config_loader_if if_near ();
    gpio_config_loader_if if_far ();

    assign if_near.gpio_defaults   = dflt;
    assign if_near.serial_data_in  = sdi;
    assign if_near.serial_shift    = shift;
    assign if_near.serial_load     = load;
    assign if_near.defaults_reload = reload;

    assign if_far.gpio_defaults    = dflt;
    assign if_far.serial_data_in   = if_near.serial_data_out;
    assign if_far.serial_shift     = shift;
    assign if_far.serial_load      = load;
    assign if_far.defaults_reload  = reload;

    gpio_config_loader #(.CFG_WIDTH(13), .CHECK_COUNT(1'b1)) u_near (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .pad      (if_near.slave)
    );

    gpio_config_loader #(.CFG_WIDTH(13), .CHECK_COUNT(1'b1)) u_far (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .pad      (if_far.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Shift the top n bits of w, MSB first.
    task automatic shift_bits(input logic [12:0] w, input int n);
        for (int i = 12; i > 12 - n; i--) begin
            sdi   = w[i];
            shift = 1'b1;
            tick();
        end
        shift = 1'b0;
        sdi   = 1'b0;
    endtask

    task automatic do_load();
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic do_reload();
        reload = 1'b1;
        tick();
        reload = 1'b0;
    endtask

    initial begin
        logic [25:0] stream;
        rst    = 1'b1;
        dflt   = 13'h0402;
        sdi    = 1'b0;
        shift  = 1'b0;
        load   = 1'b0;
        reload = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_cfg",     32'(if_near.config_word),     32'h0402);
        check("rst_outenb",  32'(if_near.gpio_outenb),     32'd1);
        check("rst_dm",      32'(if_near.gpio_dm),         32'd1);
        check("rst_mgmt",    32'(if_near.mgmt_ena),        32'd0);
        check("rst_sdo",     32'(if_near.serial_data_out), 32'd0);
        check("rst_err",     32'(if_near.load_err),        32'd0);
        check("rst_upd",     32'(if_near.config_updated),  32'd0);

        // Full 13-bit load of 1803
        shift_bits(13'h1803, 13);
        check("sh_sdo",      32'(if_near.serial_data_out), 32'd1);
        check("sh_cfg_hold", 32'(if_near.config_word),     32'h0402);
        do_load();
        check("ld_cfg",      32'(if_near.config_word),     32'h1803);
        check("ld_dm",       32'(if_near.gpio_dm),         32'd6);
        check("ld_mgmt",     32'(if_near.mgmt_ena),        32'd1);
        check("ld_outenb",   32'(if_near.gpio_outenb),     32'd1);
        check("ld_upd",      32'(if_near.config_updated),  32'd1);
        tick();
        check("ld_upd_end",  32'(if_near.config_updated),  32'd0);

        // Reload restores defaults and pulses config_updated
        do_reload();
        check("rl_cfg",      32'(if_near.config_word),     32'h0402);
        check("rl_upd",      32'(if_near.config_updated),  32'd1);
        tick();

        // Short shift rejected
        shift_bits(13'h1FFF, 7);
        do_load();
        check("short_cfg",   32'(if_near.config_word),     32'h0402);
        check("short_err",   32'(if_near.load_err),        32'd1);
        check("short_upd",   32'(if_near.config_updated),  32'd0);
        tick();
        check("err_sticky",  32'(if_near.load_err),        32'd1);
        do_reload();
        check("err_clr",     32'(if_near.load_err),        32'd0);
        tick();

        // Load and shift together: load takes the pre-shift word, count ends at 0
        shift_bits(13'h1555, 13);
        sdi   = 1'b1;
        shift = 1'b1;
        load  = 1'b1;
        tick();
        shift = 1'b0;
        load  = 1'b0;
        sdi   = 1'b0;
        check("ldsh_cfg",    32'(if_near.config_word),     32'h1555);
        check("ldsh_err",    32'(if_near.load_err),        32'd0);
        do_load();
        check("ldsh_cnt0",   32'(if_near.load_err),        32'd1);
        check("ldsh_keep",   32'(if_near.config_word),     32'h1555);
        do_reload();

        // Two-pad chain: far pad gets the first 13 bits, near pad the last 13
        stream = {13'h0C00, 13'h0001};
        for (int m = 0; m < 26; m++) begin
            sdi   = stream[25 - m];
            shift = 1'b1;
            tick();
            if (m >= 12) begin
                check($sformatf("lag_%0d", m), 32'(if_near.serial_data_out), 32'(stream[25 - (m - 12)]));
            end
        end
        shift = 1'b0;
        sdi   = 1'b0;
        do_load();
        check("chain_near",  32'(if_near.config_word),     32'h0001);
        check("chain_far",   32'(if_far.config_word),      32'h0C00);
        check("chain_fupd",  32'(if_far.config_updated),   32'd1);
        do_reload();

        // Reload beats load in the same cycle
        shift_bits(13'h1FFF, 13);
        reload = 1'b1;
        load   = 1'b1;
        tick();
        reload = 1'b0;
        load   = 1'b0;
        check("rlld_cfg",    32'(if_near.config_word),     32'h0402);
        check("rlld_err",    32'(if_near.load_err),        32'd0);
        check("rlld_upd",    32'(if_near.config_updated),  32'd1);
        do_load();
        check("rlld_cnt0",   32'(if_near.load_err),        32'd1);
        do_reload();

        // Reset mid-shift discards the partial word and count
        shift_bits(13'h1FFF, 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_sdo",     32'(if_near.serial_data_out), 32'd0);
        check("mid_cfg",     32'(if_near.config_word),     32'h0402);
        shift_bits(13'h1FFF, 8);
        do_load();
        check("mid_noleak",  32'(if_near.load_err),        32'd1);
        check("mid_noleak_cfg", 32'(if_near.config_word),  32'h0402);
        do_reload();
        shift_bits(13'h0AAA, 13);
        do_load();
        check("post_cfg",    32'(if_near.config_word),     32'h0AAA);
        check("post_err",    32'(if_near.load_err),        32'd0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
